// File: rtl/arb_pkg.sv
// Shared arbiter helpers: index-width calculation and packed weight-field
// extraction, used by every arbiter in this family.
package arb_pkg;

   // Widest packed weight bus the extraction helper accepts.
   localparam int unsigned FIELD_BUS_W = 256;

   // Width of a binary index able to address n requestors (minimum 1 bit).
   function automatic int unsigned idx_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Return field idx of width w from a packed bus (field i at [i*w +: w]).
   function automatic int unsigned weight_field(
      input logic [FIELD_BUS_W-1:0] bus,
      input int unsigned            idx,
      input int unsigned            w
   );
      logic [FIELD_BUS_W-1:0] shifted;
      shifted = bus >> (idx * w);
      return shifted[31:0] & ((32'd1 << w) - 32'd1);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: grants the first set request bit searching
// ptr+1, ptr+2, ... with wrap, visiting ptr itself last. Implemented by
// rotating a doubled request vector and applying a fixed lowest-first priority.
module rr_pick
   import arb_pkg::*;
#(
   parameter int NUM_REQ = 10
) (
   input  logic [NUM_REQ-1:0]                 req,
   input  logic [idx_width(NUM_REQ)-1:0]      ptr,
   output logic [NUM_REQ-1:0]                 pick_oh,
   output logic [idx_width(NUM_REQ)-1:0]      pick_enc
);

   localparam int IDX_W = idx_width(NUM_REQ);
   // One extra bit so start + offset (at most 2*NUM_REQ-1) never overflows.
   localparam int SUM_W = IDX_W + 1;

   logic [2*NUM_REQ-1:0] w_double;
   logic [NUM_REQ-1:0]   w_rot;
   logic [SUM_W-1:0]     w_start;
   logic [SUM_W-1:0]     w_off;
   logic [SUM_W-1:0]     w_sum;
   logic [SUM_W-1:0]     w_idx;
   logic                 w_found;

   // Search starts one past the current owner; ptr = NUM_REQ-1 starts at 0.
   assign w_start  = SUM_W'(ptr) + SUM_W'(1);
   assign w_double = {req, req};
   assign w_rot    = NUM_REQ'(w_double >> w_start);

   // Fixed priority on the rotated vector: lowest set bit wins.
   always_comb begin
      w_found = 1'b0;
      w_off   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (w_rot[i]) begin
            w_found = 1'b1;
            w_off   = SUM_W'(i);
         end
      end
   end

   // Undo the rotation: absolute index = (start + offset) mod NUM_REQ.
   assign w_sum    = w_start + w_off;
   assign w_idx    = (w_sum >= SUM_W'(NUM_REQ)) ? (w_sum - SUM_W'(NUM_REQ)) : w_sum;
   assign pick_enc = w_found ? w_idx[IDX_W-1:0] : '0;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_oh
         assign pick_oh[gi] = w_found && (w_idx == SUM_W'(gi));
      end
   endgenerate

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter. The current owner keeps the grant for up to
// its weight in consecutive non-hold cycles; hold cycles are free. When the
// owner's turn ends (credit spent or request dropped) the rotating picker
// chooses the next requestor in the same cycle, so there is no bubble.
module wrr_arbiter
   import arb_pkg::*;
#(
   parameter int NUM_REQ  = 10,
   parameter int WEIGHT_W = 4
) (
   input  logic                               clk,
   input  logic                               rst_b,
   input  logic [NUM_REQ-1:0]                 req,
   input  logic [NUM_REQ-1:0]                 hold,
   input  logic [NUM_REQ*WEIGHT_W-1:0]        weight,
   output logic [NUM_REQ-1:0]                 gnt,
   output logic [idx_width(NUM_REQ)-1:0]      gnt_enc,
   output logic                               gnt_vld
);

   localparam int IDX_W = idx_width(NUM_REQ);
   localparam int BUS_W = NUM_REQ * WEIGHT_W;

   logic [IDX_W-1:0]       r_ptr;
   logic                   r_owner_vld;
   logic [WEIGHT_W-1:0]    r_credit;

   logic [IDX_W-1:0]       w_ptr_next;
   logic                   w_owner_vld_next;
   logic [WEIGHT_W-1:0]    w_credit_next;

   logic                   w_continue;
   logic [NUM_REQ-1:0]     w_owner_oh;
   logic [NUM_REQ-1:0]     w_pick_oh;
   logic [IDX_W-1:0]       w_pick_enc;
   logic [FIELD_BUS_W-1:0] w_weight_bus;
   logic [WEIGHT_W-1:0]    w_pick_wt;

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_pick (
      .req      (req),
      .ptr      (r_ptr),
      .pick_oh  (w_pick_oh),
      .pick_enc (w_pick_enc)
   );

   // The owner keeps the grant while it requests and either holds or has credit.
   assign w_continue = r_owner_vld && req[r_ptr] && (hold[r_ptr] || (r_credit != '0));

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_owner_oh
         assign w_owner_oh[gi] = (r_ptr == IDX_W'(gi));
      end
   endgenerate

   assign gnt     = w_continue ? w_owner_oh : w_pick_oh;
   assign gnt_enc = w_continue ? r_ptr      : w_pick_enc;
   assign gnt_vld = |gnt;

   // Zero-extend the packed weights to the helper's fixed bus width.
   always_comb begin
      w_weight_bus             = '0;
      w_weight_bus[BUS_W-1:0]  = weight;
   end

   // Weight is sampled only for a fresh pick; a running quantum ignores changes.
   assign w_pick_wt = WEIGHT_W'(weight_field(w_weight_bus, int'(w_pick_enc), WEIGHT_W));

   // Next-state: charge credit on non-hold continue, reload on a new pick.
   always_comb begin
      w_ptr_next       = r_ptr;
      w_owner_vld_next = r_owner_vld;
      w_credit_next    = r_credit;
      if (w_continue) begin
         if (!hold[r_ptr]) begin
            w_credit_next = r_credit - WEIGHT_W'(1);
         end
      end else if (|req) begin
         w_ptr_next       = w_pick_enc;
         w_owner_vld_next = 1'b1;
         // The grant issued this cycle uses one unit; weight 0 counts as 1.
         w_credit_next    = (w_pick_wt == '0) ? '0 : (w_pick_wt - WEIGHT_W'(1));
      end else begin
         w_owner_vld_next = 1'b0;
      end
   end

   // State registers; reset makes requestor 0 the first in line.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_ptr       <= IDX_W'(NUM_REQ - 1);
         r_owner_vld <= 1'b0;
         r_credit    <= '0;
      end else begin
         r_ptr       <= w_ptr_next;
         r_owner_vld <= w_owner_vld_next;
         r_credit    <= w_credit_next;
      end
   end

endmodule

// File: doc/wrr_arbiter.md
WRR_ARBITER -- requirements
Module: wrr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 10, number of requestors; legal values are 2 and above.
REQ-002 Parameter WEIGHT_W, default 4, width of each per-requestor weight field.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_b  input  1  asynchronous, active-low reset.
REQ-005 req  input  NUM_REQ  request vector; bit i is requestor i.
REQ-006 hold  input  NUM_REQ  per-requestor lock; hold[i] keeps an active grant on i without charging credit.
REQ-007 weight  input  NUM_REQ*WEIGHT_W  packed quanta; field i is bits [i*WEIGHT_W +: WEIGHT_W].
REQ-008 gnt  output  NUM_REQ  one-hot or all-zero grant, combinational from current state and inputs.
REQ-009 gnt_enc  output  $clog2(NUM_REQ)  binary index of the asserted gnt bit; 0 when gnt is all-zero.
REQ-010 gnt_vld  output  1  equals OR of gnt.

Function
REQ-011 State consists of: owner index (ptr), owner_vld flag, and credit counter of WEIGHT_W bits.
REQ-012 Effective weight is weight[i]; a weight of 0 is treated as 1.
REQ-013 CONTINUE condition: owner_vld and req[ptr] and (hold[ptr] or credit != 0). When true, gnt is the one-hot of ptr.
REQ-014 In CONTINUE with hold[ptr]=1, credit is unchanged, so hold cycles are free.
REQ-015 In CONTINUE with hold[ptr]=0, credit decrements by 1.
REQ-016 When CONTINUE is false, a rotating-priority pick grants the first set req bit searching ptr+1, ptr+2, ... with wrap modulo NUM_REQ.
REQ-017 The rotating search includes ptr itself last.
REQ-018 On a new pick of index k: ptr <= k, owner_vld <= 1, credit <= effective weight[k] - 1.
REQ-019 Each requestor therefore receives at most effective-weight consecutive non-hold grants per turn.
REQ-020 When CONTINUE is false and req is all-zero: gnt is 0, owner_vld <= 0, ptr and credit hold.
REQ-021 If the owner deasserts req, its remaining credit is forfeited and re-arbitration occurs in the same cycle, with no bubble.
REQ-022 Single requestor with expired credit is re-picked in the same cycle with a fresh quantum; gnt stays high continuously.
REQ-023 A weight change is sampled only at a new pick; a quantum in progress is unaffected.
REQ-024 hold on a non-owner bit has no effect.
REQ-025 hold on the owner while req[ptr]=0 has no effect (req has precedence).
REQ-026 Grant latency from req assertion with no owner active is 0 cycles (combinational).
REQ-027 gnt never has more than one bit set under any input combination.

Reset
REQ-028 While rst_b=0: ptr = NUM_REQ-1, owner_vld = 0, credit = 0; requestor 0 has highest priority on first arbitration.
REQ-029 Outputs during reset follow REQ-016 from the reset state; they are combinational and not forced to 0.
REQ-030 Reset deassertion mid-quantum discards all quantum and hold history.

Structure
REQ-031 Package arb_pkg holds the IDX_W = $clog2(NUM_REQ) helper function and a weight-field extraction function, shared with other arbiters.
REQ-032 A single sub-module rr_pick (NUM_REQ parameter; inputs req and ptr; outputs one-hot and encoded pick) implements REQ-016 and REQ-017 using the double-width rotate and fixed-priority method.
REQ-033 No other sub-modules.

Verification
REQ-034 NUM_REQ=4, all weights=1, req=4'b1111 for 8 cycles after reset -> gnt_enc sequence 0,1,2,3,0,1,2,3.
REQ-035 Weights {3,1,2,1} (index 0..3), req=4'b1111 -> gnt_enc sequence 0,0,0,1,2,2,3,0,0,0.
REQ-036 Weight[1]=2, req=4'b0010 only, 6 cycles -> gnt=4'b0010 every cycle, credit reloads every 2 cycles, no gap.
REQ-037 Weight[0]=2, req=4'b0011, hold[0]=1 for cycles 1-4 after grant then 0 -> requestor 0 granted 6 consecutive cycles, then requestor 1.
REQ-038 Weight[2]=4, owner 2 drops req after 1 grant while req[3]=1 -> gnt_enc=3 in that same cycle; requestor 2 later gets a fresh 4-cycle quantum.
REQ-039 rst_b asserted mid-quantum of requestor 2, with req=4'b1111 at release -> first gnt_enc=0; random stimulus checks REQ-027 and gnt_enc/gnt_vld consistency every cycle.
